// File: rtl/opl3_axi4lite_bridge.sv
// opl3_axi4lite_bridge
// AXI4-Lite slave that queues CPU register writes and replays them as
// paced one-cycle write strobes towards one or more OPL3 synthesis cores.
// Also provides a status word (FIFO state and drop counter) and a
// control register that flushes the queue.
module opl3_axi4lite_bridge #(
  parameter int NUM_CORES  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_awvalid_i,
  output logic                 cfg_awready_o,
  input  logic [31:0]          cfg_awaddr_i,
  input  logic                 cfg_wvalid_i,
  output logic                 cfg_wready_o,
  input  logic [31:0]          cfg_wdata_i,
  input  logic [3:0]           cfg_wstrb_i,
  output logic                 cfg_bvalid_o,
  input  logic                 cfg_bready_i,
  output logic [1:0]           cfg_bresp_o,
  input  logic                 cfg_arvalid_i,
  output logic                 cfg_arready_o,
  input  logic [31:0]          cfg_araddr_i,
  output logic                 cfg_rvalid_o,
  input  logic                 cfg_rready_i,
  output logic [31:0]          cfg_rdata_o,
  output logic [1:0]           cfg_rresp_o,
  output logic [NUM_CORES-1:0] opl3_we_o,
  output logic [8:0]           opl3_adr_o,
  output logic [7:0]           opl3_data_o
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = CORE_W + 17;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Fill level reported in an 8-bit status field, clipped at 255.
  function automatic logic [7:0] sat_fill(input logic [PTR_W:0] lvl);
    if (int'(lvl) > 255) return 8'hFF;
    else                 return 8'(lvl);
  endfunction

  // Drop counter sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Write-channel holding registers
  logic             aw_held_q;
  logic [15:2]      awaddr_q;
  logic             w_held_q;
  logic [7:0]       wdata_q;
  logic             wstrb0_q;

  // Response / read registers
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [15:0]      drop_q;

  // Write queue
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;

  // Drain engine
  state_t                state_q;
  logic [7:0]            gap_q;
  logic [NUM_CORES-1:0]  we_q;
  logic [8:0]            adr_q;
  logic [7:0]            data_q;

  // Combinational decode
  logic             aw_acc, w_acc, aw_have, w_have;
  logic [15:2]      cur_addr;
  logic [7:0]       cur_data;
  logic             cur_strb0;
  logic [3:0]       core_field;
  logic             core_ok, is_ctrl, is_push;
  logic             commit, do_push, do_flush, do_drop;
  logic [PTR_W:0]   fifo_level;
  logic             fifo_empty, fifo_full, pop;
  logic [ENT_W-1:0] push_ent, head_ent;
  logic [CORE_W-1:0] head_core;
  logic [31:0]      status_word;
  logic             ar_acc;
  logic             unused_bits;

  assign aw_acc  = cfg_awvalid_i & ~aw_held_q;
  assign w_acc   = cfg_wvalid_i  & ~w_held_q;
  // A channel arriving this cycle counts as present, so AW+W together
  // commit on the very edge they are accepted.
  assign aw_have = aw_held_q | aw_acc;
  assign w_have  = w_held_q  | w_acc;

  assign cur_addr  = aw_held_q ? awaddr_q : cfg_awaddr_i[15:2];
  assign cur_data  = w_held_q  ? wdata_q  : cfg_wdata_i[7:0];
  assign cur_strb0 = w_held_q  ? wstrb0_q : cfg_wstrb_i[0];

  // The whole field between the register index and the space bit selects
  // the core, so out-of-range core numbers beyond CORE_W are rejected too.
  assign core_field = cur_addr[14:11];
  assign core_ok    = ({28'd0, core_field} < 32'(NUM_CORES));
  assign is_ctrl    = cur_addr[15];
  assign is_push    = ~is_ctrl & core_ok & cur_strb0;

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Only pushing commits wait for room; control and dropped writes never do.
  assign commit   = aw_have & w_have & ~bvalid_q & (~is_push | ~fifo_full);
  assign do_push  = commit & is_push;
  assign do_flush = commit & is_ctrl & cur_data[0];
  assign do_drop  = commit & ~is_ctrl & ~is_push;

  assign push_ent  = {core_field[CORE_W-1:0], cur_addr[10:2], cur_data};
  assign head_ent  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_core = head_ent[ENT_W-1 -: CORE_W];

  // A flush in the same cycle also cancels a pop, so nothing queued
  // before the flush reaches a core.
  assign pop = (state_q == S_IDLE) & ~fifo_empty & ~do_flush;

  assign status_word = {drop_q, sat_fill(fifo_level), 6'd0, fifo_full, fifo_empty};
  assign ar_acc      = cfg_arvalid_i & ~rvalid_q;

  assign cfg_awready_o = ~aw_held_q;
  assign cfg_wready_o  = ~w_held_q;
  assign cfg_bvalid_o  = bvalid_q;
  assign cfg_bresp_o   = bresp_q;
  assign cfg_arready_o = ~rvalid_q;
  assign cfg_rvalid_o  = rvalid_q;
  assign cfg_rdata_o   = rdata_q;
  assign cfg_rresp_o   = RESP_OKAY;
  assign opl3_we_o     = we_q;
  assign opl3_adr_o    = adr_q;
  assign opl3_data_o   = data_q;

  assign unused_bits = ^{cfg_awaddr_i[31:16], cfg_awaddr_i[1:0],
                         cfg_wdata_i[31:8], cfg_wstrb_i[3:1],
                         cfg_araddr_i[31:16], cfg_araddr_i[14:0]};

  // Track which write channels are parked waiting for their partner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (commit)      aw_held_q <= 1'b0;
      else if (aw_acc) aw_held_q <= 1'b1;
      if (commit)      w_held_q  <= 1'b0;
      else if (w_acc)  w_held_q  <= 1'b1;
    end
  end

  // Capture address and data payloads as each channel is accepted.
  always_ff @(posedge clk_i) begin
    if (aw_acc) awaddr_q <= cfg_awaddr_i[15:2];
    if (w_acc) begin
      wdata_q  <= cfg_wdata_i[7:0];
      wstrb0_q <= cfg_wstrb_i[0];
    end
  end

  // Write response: raised by a commit, lowered by the B handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= (~is_ctrl & ~core_ok) ? RESP_SLVERR : RESP_OKAY;
    end else if (cfg_bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  // Count writes that were acknowledged but not queued.
  always_ff @(posedge clk_i) begin
    if (rst_i || do_flush) drop_q <= 16'd0;
    else if (do_drop)      drop_q <= sat_inc16(drop_q);
  end

  // Queue pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || do_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      if (pop)     rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Queue storage.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_ent;
  end

  // Read channel: status snapshot or zero, held until R handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else if (ar_acc) begin
      rvalid_q <= 1'b1;
      rdata_q  <= cfg_araddr_i[15] ? status_word : 32'd0;
    end else if (cfg_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  // Drain engine: pop, strobe one core for a cycle, then idle WR_GAP cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= 8'd0;
      we_q    <= '0;
      adr_q   <= 9'd0;
      data_q  <= 8'd0;
    end else begin
      we_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_WRITE;
            we_q    <= NUM_CORES'(1) << head_core;
            adr_q   <= head_ent[16:8];
            data_q  <= head_ent[7:0];
          end
        end
        S_WRITE: begin
          if (do_flush || WR_GAP == 0) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_GAP;
            gap_q   <= 8'(WR_GAP - 1);
          end
        end
        S_GAP: begin
          if (do_flush || gap_q == 8'd0) state_q <= S_IDLE;
          else                           gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opl3_axi4lite_bridge.sv
// Testbench for opl3_axi4lite_bridge: directed sequence with randomized
// payloads, scored against a queue-based model of the expected strobes.
module tb_opl3_axi4lite_bridge;

  localparam int NC  = 2;
  localparam int FD  = 4;
  localparam int GAP = 3;

  typedef struct packed {
    logic [1:0] core;
    logic [8:0] adr;
    logic [7:0] dat;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NC-1:0] we;
  logic [8:0]    adr;
  logic [7:0]    dat;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  ent_t        exp_q[$];
  int          strobe_cyc[$];
  int          n_strobe = 0;
  int          awlow = 0;
  logic [8:0]  last_adr = 9'd0;
  logic [7:0]  last_dat = 8'd0;
  logic [15:0] m_drop = 16'd0;
  int          g_hs_cyc = 0;
  int          g_b_cyc = 0;

  opl3_axi4lite_bridge #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .WR_GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_awvalid_i(awvalid), .cfg_awready_o(awready), .cfg_awaddr_i(awaddr),
    .cfg_wvalid_i(wvalid), .cfg_wready_o(wready), .cfg_wdata_i(wdata),
    .cfg_wstrb_i(wstrb),
    .cfg_bvalid_o(bvalid), .cfg_bready_i(bready), .cfg_bresp_o(bresp),
    .cfg_arvalid_i(arvalid), .cfg_arready_o(arready), .cfg_araddr_i(araddr),
    .cfg_rvalid_o(rvalid), .cfg_rready_i(rready), .cfg_rdata_o(rdata),
    .cfg_rresp_o(rresp),
    .opl3_we_o(we), .opl3_adr_o(adr), .opl3_data_o(dat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  1);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_bresp",   bresp,   0);
    chk("rst_arready", arready, 1);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_rresp",   rresp,   0);
    chk("rst_we",      we,      0);
    chk("rst_adr",     adr,     0);
    chk("rst_data",    dat,     0);
  endtask

  function automatic logic [31:0] reg_addr(input logic [3:0] core, input logic [8:0] idx);
    logic [31:0] a;
    a        = $urandom;
    a[15]    = 1'b0;
    a[14:11] = core;
    a[10:2]  = idx;
    return a;
  endfunction

  // One AXI write; W and AW may each be delayed by a number of cycles.
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_a, w_a, flush = 0;
    int t = 0, wt = 0;
    logic [3:0] core;
    logic [1:0] er = 2'b00;
    ent_t e;
    if (addr[15]) begin
      flush = data[0];
    end else begin
      core = addr[14:11];
      if (core >= NC) begin
        er = 2'b10;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else if (!strb[0]) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        e.core = core[1:0]; e.adr = addr[10:2]; e.dat = data[7:0];
        exp_q.push_back(e);
      end
    end
    while (!(aw_done && w_done) && t < 200) begin
      awvalid = !aw_done && (t >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (t >= w_dly);
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      if (aw_done && !w_done) chk("awready_held", awready, 0);
      if (w_done && !aw_done) chk("wready_held",  wready,  0);
      aw_a = awvalid && awready;
      w_a  = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_a;
      w_done  = w_done | w_a;
      t++;
    end
    g_hs_cyc = cyc;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (t >= 200) chk("aw_w_timeout", 1, 0);
    @(negedge clk);
    while (!bvalid && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 100) chk("bvalid_timeout", 1, 0);
    g_b_cyc = cyc;
    chk("bresp", bresp, er);
    @(posedge clk); #1;
    if (flush) begin
      exp_q.delete();
      m_drop = 16'd0;
    end
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data);
    bit acc = 0;
    int t = 0;
    arvalid = 1'b1;
    araddr  = addr;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 1'b0;
    if (!acc) chk("ar_timeout", 1, 0);
    @(negedge clk);
    chk("rvalid_lat", rvalid, 1);
    chk("rresp", rresp, 0);
    data = rdata;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", t >= 500, 0);
    repeat (GAP + 4) @(posedge clk);
    #1;
  endtask

  // Strobe monitor: every pulse must match the next expected queue entry.
  initial begin
    ent_t e;
    logic prev_nz;
    prev_nz = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awready === 1'b0) awlow++;
        if (we !== '0) begin
          chk("pulse_1cyc", prev_nz, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", we, 0);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_we",   we,  2'b01 << e.core);
            chk("strobe_adr",  adr, e.adr);
            chk("strobe_data", dat, e.dat);
            last_adr = e.adr;
            last_dat = e.dat;
          end
          strobe_cyc.push_back(cyc);
          n_strobe++;
          prev_nz = 1'b1;
        end else begin
          chk("adr_hold",  adr, last_adr);
          chk("data_hold", dat, last_dat);
          prev_nz = 1'b0;
        end
      end else begin
        prev_nz = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single write, exact latencies
    strobe_cyc.delete();
    axi_wr(32'h0000_0104, 32'h0000_005A, 4'h1, 0, 0);
    chk("single_b_lat", g_b_cyc, g_hs_cyc);
    drain();
    chk("single_cnt", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) chk("single_we_lat", strobe_cyc[0], g_b_cyc + 1);
    chk("single_last_adr", adr, 9'h041);

    // Channel ordering: W first, then AW first
    n0 = n_strobe;
    axi_wr(reg_addr(4'($urandom_range(0, 1)), 9'($urandom)), $urandom, 4'h1, 3, 0);
    axi_wr(reg_addr(4'($urandom_range(0, 1)), 9'($urandom)), $urandom, 4'h1, 0, 3);
    drain();
    chk("order_cnt", n_strobe, n0 + 2);

    // Randomized mix of valid, errored and masked writes
    for (int i = 0; i < 8; i++)
      axi_wr(reg_addr(4'($urandom_range(0, 3)), 9'($urandom)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
    drain();
    axi_rd(32'h0000_8000, rd);
    chk("rand_status", rd, {m_drop, 8'd0, 8'd1});
    axi_rd(32'h0000_0104, rd);
    chk("reg_space_read", rd, 0);

    // Backpressure with 8 back-to-back writes
    strobe_cyc.delete();
    awlow = 0;
    for (int i = 0; i < 8; i++)
      axi_wr(reg_addr(4'($urandom_range(0, 1)), 9'($urandom)), $urandom, 4'h1, 0, 0);
    axi_rd(32'h0000_8000, rd);
    chk("bp_full_bit", rd[1], 1);
    chk("bp_awready_low", awlow > 0, 1);
    drain();
    chk("bp_cnt", strobe_cyc.size(), 8);
    for (int i = 1; i < strobe_cyc.size(); i++)
      chk("bp_spacing", strobe_cyc[i] - strobe_cyc[i-1], GAP + 2);

    // Error responses and drop counter
    axi_wr(32'h0000_8000, 32'h1, 4'hF, 0, 0);
    n0 = n_strobe;
    axi_wr(32'h0000_1800 | 32'h0000_0010, $urandom, 4'h1, 0, 0);
    axi_wr(32'h0000_0020, $urandom, 4'h0, 0, 0);
    drain();
    chk("err_no_strobe", n_strobe, n0);
    axi_rd(32'h0000_8000, rd);
    chk("err_status", rd, 32'h0002_0001);

    // Flush with entries queued
    for (int i = 0; i < 5; i++)
      axi_wr(reg_addr(4'($urandom_range(0, 1)), 9'($urandom)), $urandom, 4'h1, 0, 0);
    axi_wr(32'h0000_8000, 32'h1, 4'h1, 0, 0);
    n0 = n_strobe;
    repeat (30) @(posedge clk); #1;
    chk("flush_no_strobe", n_strobe, n0);
    axi_rd(32'h0000_8000, rd);
    chk("flush_status", rd, 32'h0000_0001);
    axi_wr(reg_addr(4'd1, 9'h1AB), 32'h0000_00C3, 4'h1, 0, 0);
    drain();
    chk("post_flush_cnt", n_strobe, n0 + 1);

    // Reset during GAP with entries queued and a read response pending
    for (int i = 0; i < 5; i++)
      axi_wr(reg_addr(4'($urandom_range(0, 1)), 9'($urandom)), $urandom, 4'h1, 0, 0);
    rready  = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h0000_8000;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    last_adr = 9'd0;
    last_dat = 8'd0;
    m_drop   = 16'd0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst    = 1'b0;
    rready = 1'b1;
    n0 = n_strobe;
    repeat (40) @(posedge clk); #1;
    chk("post_reset_no_strobe", n_strobe, n0);
    axi_rd(32'h0000_8000, rd);
    chk("post_reset_status", rd, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
